// File: rtl/mem_pkg.sv
// ============================================================================
// Module : mem_pkg
// Brief  : Shared types for the memory port arbiter (port ids, FSM states,
//          response bundle).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [0:0] {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_e;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] data;
        logic              err;
    } resp_t;

endpackage : mem_pkg

`default_nettype wire

// File: rtl/mem_addr_check.sv
// ============================================================================
// Module : mem_addr_check
// Brief  : Combinational word-alignment and address-range check for one port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_addr_check
    import mem_pkg::*;
#(
    parameter logic [WORD_W-1:0] MEM_BASE = 32'h0000_0000,
    parameter logic [WORD_W-1:0] MEM_SIZE = 32'h0001_0000
) (
    input  logic [WORD_W-1:0] addr,
    output logic              err
);

    // One extra bit so BASE+SIZE past 2^32 stays a valid upper bound.
    logic [WORD_W:0] w_addr_x;
    logic [WORD_W:0] w_lo_x;
    logic [WORD_W:0] w_hi_x;

    assign w_addr_x = {1'b0, addr};
    assign w_lo_x   = {1'b0, MEM_BASE};
    assign w_hi_x   = w_lo_x + {1'b0, MEM_SIZE};

    assign err = (addr[1:0] != 2'b00) || (w_addr_x < w_lo_x) || (w_addr_x >= w_hi_x);

endmodule : mem_addr_check

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Fetch/data arbiter in front of a single-port memory; one tagged
//          response per request, data priority with a fetch starvation guard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter logic [WORD_W-1:0] MEM_BASE     = 32'h0000_0000,
    parameter logic [WORD_W-1:0] MEM_SIZE     = 32'h0001_0000,
    parameter int unsigned       STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [WORD_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_resp_valid,
    output logic [WORD_W-1:0] if_resp_data,
    output logic              if_resp_err,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_we,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_resp_valid,
    output logic [WORD_W-1:0] d_resp_rdata,
    output logic              d_resp_err,
    output logic              mem_write_enabled,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_w_data,
    input  logic [WORD_W-1:0] mem_r_data,
    output logic              busy
);

    localparam int              CNT_W      = $clog2(STARVE_LIMIT + 2);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    state_e              state_q,   state_d;
    port_e               port_q,    port_d;
    logic                we_q,      we_d;
    logic                err_q,     err_d;
    logic [WORD_W-1:0]   addr_q,    addr_d;
    logic [WORD_W-1:0]   wdata_q,   wdata_d;
    logic                mem_we_q,  mem_we_d;
    logic [CNT_W-1:0]    starve_q,  starve_d;
    resp_t               if_resp_q, if_resp_d;
    resp_t               d_resp_q,  d_resp_d;

    logic w_if_err;
    logic w_d_err;
    logic w_grant_if;
    logic w_grant_d;

    mem_addr_check #(
        .MEM_BASE (MEM_BASE),
        .MEM_SIZE (MEM_SIZE)
    ) u_if_check (
        .addr (if_addr),
        .err  (w_if_err)
    );

    mem_addr_check #(
        .MEM_BASE (MEM_BASE),
        .MEM_SIZE (MEM_SIZE)
    ) u_d_check (
        .addr (d_addr),
        .err  (w_d_err)
    );

    // Readys are gated by rst so every output is 0 while reset is held.
    assign w_grant_if = rst && (state_q == IDLE) && if_req_valid &&
                        (!d_req_valid || (starve_q == STARVE_MAX));
    assign w_grant_d  = rst && (state_q == IDLE) && d_req_valid && !w_grant_if;

    always_comb begin
        state_d         = state_q;
        port_d          = port_q;
        we_d            = we_q;
        err_d           = err_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        mem_we_d        = 1'b0;
        if_resp_d       = if_resp_q;
        d_resp_d        = d_resp_q;
        if_resp_d.valid = 1'b0;
        d_resp_d.valid  = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_grant_if || w_grant_d) begin
                    state_d  = ISSUE;
                    port_d   = w_grant_if ? PORT_IF : PORT_D;
                    we_d     = w_grant_d && d_we;
                    err_d    = w_grant_if ? w_if_err : w_d_err;
                    addr_d   = w_grant_if ? if_addr : d_addr;
                    wdata_d  = (w_grant_d && d_we) ? d_wdata : '0;
                    mem_we_d = w_grant_d && d_we && !w_d_err;
                end
            end
            ISSUE: begin
                state_d = IDLE;
                if (port_q == PORT_IF) begin
                    if_resp_d.valid = !if_flush;
                    if_resp_d.data  = (err_q || we_q) ? '0 : mem_r_data;
                    if_resp_d.err   = err_q;
                end else begin
                    d_resp_d.valid  = 1'b1;
                    d_resp_d.data   = (err_q || we_q) ? '0 : mem_r_data;
                    d_resp_d.err    = err_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (if_req_valid && !w_grant_if) begin
            starve_d = (starve_q == STARVE_MAX) ? STARVE_MAX : starve_q + 1'b1;
        end else begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            port_q    <= PORT_IF;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_we_q  <= 1'b0;
            starve_q  <= '0;
            if_resp_q <= '0;
            d_resp_q  <= '0;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            we_q      <= we_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mem_we_q  <= mem_we_d;
            starve_q  <= starve_d;
            if_resp_q <= if_resp_d;
            d_resp_q  <= d_resp_d;
        end
    end

    assign if_req_ready      = w_grant_if;
    assign d_req_ready       = w_grant_d;
    assign busy              = (state_q != IDLE);
    assign mem_write_enabled = mem_we_q;
    assign mem_addr          = addr_q;
    assign mem_w_data        = wdata_q;

    // A redirect during the response cycle still kills the fetch pulse.
    assign if_resp_valid     = if_resp_q.valid && !if_flush;
    assign if_resp_data      = if_resp_q.data;
    assign if_resp_err       = if_resp_q.err;
    assign d_resp_valid      = d_resp_q.valid;
    assign d_resp_rdata      = d_resp_q.data;
    assign d_resp_err        = d_resp_q.err;

endmodule : mem_port_arbiter

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Directed plus randomized bench for mem_port_arbiter against a
//          transaction-level reference model and a behavioural memory.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_port_arbiter;

    localparam logic [31:0] MEM_BASE     = 32'h0000_0000;
    localparam logic [31:0] MEM_SIZE     = 32'h0001_0000;
    localparam int          STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_flush;
    logic [31:0] if_addr;
    logic        if_resp_valid, if_resp_err;
    logic [31:0] if_resp_data;
    logic        d_req_valid, d_req_ready, d_we;
    logic [31:0] d_addr, d_wdata;
    logic        d_resp_valid, d_resp_err;
    logic [31:0] d_resp_rdata;
    logic        mem_write_enabled;
    logic [31:0] mem_addr, mem_w_data, mem_r_data;
    logic        busy;

    mem_port_arbiter #(
        .MEM_BASE     (MEM_BASE),
        .MEM_SIZE     (MEM_SIZE),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .if_req_valid      (if_req_valid),
        .if_req_ready      (if_req_ready),
        .if_addr           (if_addr),
        .if_flush          (if_flush),
        .if_resp_valid     (if_resp_valid),
        .if_resp_data      (if_resp_data),
        .if_resp_err       (if_resp_err),
        .d_req_valid       (d_req_valid),
        .d_req_ready       (d_req_ready),
        .d_we              (d_we),
        .d_addr            (d_addr),
        .d_wdata           (d_wdata),
        .d_resp_valid      (d_resp_valid),
        .d_resp_rdata      (d_resp_rdata),
        .d_resp_err        (d_resp_err),
        .mem_write_enabled (mem_write_enabled),
        .mem_addr          (mem_addr),
        .mem_w_data        (mem_w_data),
        .mem_r_data        (mem_r_data),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for SimulatedMemory: combinational read, clocked write.
    bit [31:0] sim_mem [16384];
    always @(posedge clk) if (mem_write_enabled) sim_mem[mem_addr[15:2]] <= mem_w_data;
    assign mem_r_data = sim_mem[mem_addr[15:2]];

    int total = 0;
    int bad   = 0;

    // Reference model: one outstanding transaction and one pending response.
    bit [31:0]   ref_mem [16384];
    bit          m_busy, m_port_if, m_we, m_err;
    logic [31:0] m_addr, m_wdata, m_last_addr, m_last_wdata;
    bit          r_pend, r_if, r_flushed, r_err;
    logic [31:0] r_data;
    int          starve;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit addr_err(input logic [31:0] a);
        longint x;
        x = {32'h0, a};
        return (a[1:0] != 2'b00) || (x < {32'h0, MEM_BASE}) ||
               (x >= {32'h0, MEM_BASE} + {32'h0, MEM_SIZE});
    endfunction

    task automatic drv(input bit ifv, input logic [31:0] ifa, input bit dv, input bit we,
                       input logic [31:0] da, input logic [31:0] wd, input bit fl);
        if_req_valid = ifv; if_addr = ifa; if_flush = fl;
        d_req_valid = dv; d_we = we; d_addr = da; d_wdata = wd;
    endtask

    task automatic idle();
        drv(0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    endtask

    // Sample at the falling edge, compare against the model, advance it.
    task automatic tick();
        bit          g_if, g_d, exp_ifv;
        logic [31:0] rd;
        @(negedge clk);
        if (!rst) begin
            chk("rst_if_ready", if_req_ready, 0);
            chk("rst_d_ready", d_req_ready, 0);
            chk("rst_if_resp_valid", if_resp_valid, 0);
            chk("rst_d_resp_valid", d_resp_valid, 0);
            chk("rst_if_resp_data", if_resp_data, 0);
            chk("rst_d_resp_rdata", d_resp_rdata, 0);
            chk("rst_errs", {if_resp_err, d_resp_err}, 0);
            chk("rst_mem_we", mem_write_enabled, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_w_data", mem_w_data, 0);
            chk("rst_busy", busy, 0);
            m_busy = 0; r_pend = 0; starve = 0;
            m_last_addr = 32'h0; m_last_wdata = 32'h0;
        end else begin
            exp_ifv = r_pend && r_if && !r_flushed && !if_flush;
            chk("if_resp_valid", if_resp_valid, exp_ifv);
            chk("d_resp_valid", d_resp_valid, r_pend && !r_if);
            if (exp_ifv) begin
                chk("if_resp_data", if_resp_data, r_data);
                chk("if_resp_err", if_resp_err, r_err);
            end
            if (r_pend && !r_if) begin
                chk("d_resp_rdata", d_resp_rdata, r_data);
                chk("d_resp_err", d_resp_err, r_err);
            end
            r_pend = 0;
            g_if = 0; g_d = 0;
            if (m_busy) begin
                chk("issue_busy", busy, 1);
                chk("issue_readys", {if_req_ready, d_req_ready}, 0);
                chk("issue_mem_addr", mem_addr, m_addr);
                chk("issue_mem_we", mem_write_enabled, m_we && !m_err);
                chk("issue_mem_w_data", mem_w_data, m_we ? m_wdata : 32'h0);
                rd = (m_err || m_we) ? 32'h0 : ref_mem[m_addr[15:2]];
                if (m_we && !m_err) ref_mem[m_addr[15:2]] = m_wdata;
                r_pend = 1; r_if = m_port_if; r_flushed = m_port_if && if_flush;
                r_data = rd; r_err = m_err;
                m_last_addr = m_addr; m_last_wdata = m_we ? m_wdata : 32'h0;
                m_busy = 0;
            end else begin
                if (if_req_valid && d_req_valid) begin
                    g_if = (starve == STARVE_LIMIT);
                    g_d  = !g_if;
                end else begin
                    g_if = if_req_valid;
                    g_d  = d_req_valid;
                end
                chk("idle_busy", busy, 0);
                chk("if_req_ready", if_req_ready, g_if);
                chk("d_req_ready", d_req_ready, g_d);
                chk("idle_mem_we", mem_write_enabled, 0);
                chk("idle_mem_addr_hold", mem_addr, m_last_addr);
                chk("idle_mem_w_data_hold", mem_w_data, m_last_wdata);
                if (g_if || g_d) begin
                    m_port_if = g_if;
                    m_addr    = g_if ? if_addr : d_addr;
                    m_we      = g_d && d_we;
                    m_wdata   = d_wdata;
                    m_err     = addr_err(m_addr);
                    m_busy    = 1;
                end
            end
            if (if_req_valid && !g_if) starve = (starve < STARVE_LIMIT) ? starve + 1 : STARVE_LIMIT;
            else                       starve = 0;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r == 0) return ({$urandom_range(0, 63)} << 2) + $urandom_range(1, 3);
        if (r == 1) return ($urandom_range(0, 1) == 0) ? (32'h0001_0000 + ($urandom_range(0, 15) << 2))
                                                       : 32'hFFFF_FFFC;
        return {$urandom_range(0, 63)} << 2;
    endfunction

    int exp_g [11] = '{2, 0, 2, 0, 1, 0, 2, 0, 2, 0, 1};
    int got_g;

    initial begin
        rst = 1'b0;
        idle();
        m_busy = 0; r_pend = 0; starve = 0;
        m_last_addr = 32'h0; m_last_wdata = 32'h0;
        @(posedge clk); #1;
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("lit_busy_after_reset", busy, 0);

        // Seed 0x100 through the data port, then fetch it back.
        drv(0, 0, 1, 1, 32'h100, 32'h2402_0005, 0); #1;
        chk("lit_seed_d_ready", d_req_ready, 1); tick();
        idle(); #1;
        chk("lit_seed_mem_we", mem_write_enabled, 1); tick();
        #1; chk("lit_seed_resp_rdata", d_resp_rdata, 0); tick();

        drv(1, 32'h100, 0, 0, 0, 0, 0); #1;
        chk("lit_fetch_ready", if_req_ready, 1); tick();
        idle(); #1;
        chk("lit_fetch_mem_addr", mem_addr, 32'h100); tick();
        #1;
        chk("lit_fetch_resp_valid", if_resp_valid, 1);
        chk("lit_fetch_resp_data", if_resp_data, 32'h2402_0005);
        chk("lit_fetch_resp_err", if_resp_err, 0);
        tick();

        // Store then load.
        drv(0, 0, 1, 1, 32'h40, 32'hDEAD_BEEF, 0); tick();
        idle(); #1;
        chk("lit_store_we_issue", mem_write_enabled, 1); tick();
        #1;
        chk("lit_store_we_resp", mem_write_enabled, 0);
        chk("lit_store_rdata", d_resp_rdata, 0);
        drv(0, 0, 1, 0, 32'h40, 32'h0, 0); tick();
        idle(); tick();
        #1; chk("lit_load_rdata", d_resp_rdata, 32'hDEAD_BEEF); tick();

        // Contention: both ports valid continuously.
        drv(1, 32'h104, 1, 0, 32'h108, 32'h0, 0);
        for (int c = 0; c < 11; c++) begin
            #1;
            got_g = if_req_ready ? 1 : (d_req_ready ? 2 : 0);
            chk("lit_contention_grant", got_g, exp_g[c]);
            tick();
        end
        idle(); tick(); tick();

        // Errors: misaligned store, fetch just past the top of the range.
        drv(0, 0, 1, 1, 32'h42, 32'h1111_2222, 0); tick();
        idle(); #1;
        chk("lit_err_store_no_we", mem_write_enabled, 0); tick();
        #1;
        chk("lit_err_store_err", d_resp_err, 1);
        chk("lit_err_store_rdata", d_resp_rdata, 0);
        drv(1, MEM_BASE + MEM_SIZE, 0, 0, 0, 0, 0); tick();
        idle(); tick();
        #1;
        chk("lit_err_fetch_err", if_resp_err, 1);
        chk("lit_err_fetch_data", if_resp_data, 0);
        tick();

        // Flush in the ISSUE cycle of a fetch.
        drv(1, 32'h100, 0, 0, 0, 0, 0); tick();
        drv(0, 0, 0, 0, 0, 0, 1); tick();
        drv(1, 32'h100, 0, 0, 0, 0, 0); #1;
        chk("lit_flush_suppressed", if_resp_valid, 0);
        chk("lit_flush_next_accept", if_req_ready, 1);
        tick();
        idle(); tick();
        #1; chk("lit_after_flush_data", if_resp_data, 32'h2402_0005); tick();

        // Asynchronous reset during the ISSUE cycle of a store.
        drv(0, 0, 1, 1, 32'h200, 32'h1234_5678, 0); tick();
        idle(); #1;
        chk("lit_midstore_we_before", mem_write_enabled, 1);
        rst = 1'b0; #1;
        chk("lit_midstore_we_dropped", mem_write_enabled, 0);
        chk("lit_midstore_busy", busy, 0);
        tick();
        rst = 1'b1;
        tick();
        drv(0, 0, 1, 0, 32'h200, 32'h0, 0); #1;
        chk("lit_post_reset_accept", d_req_ready, 1); tick();
        idle(); tick();
        #1; chk("lit_aborted_store_rdata", d_resp_rdata, 0); tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            drv($urandom_range(0, 3) != 0, rand_addr(),
                $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rand_addr(),
                $urandom, $urandom_range(0, 7) == 0);
            tick();
        end
        idle(); tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_port_arbiter

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Single-port memory front end that sits directly upstream of SimulatedMemory. It arbitrates between the pipeline's instruction-fetch port and its data (load/store) port, and drives SimulatedMemory's write_enabled/addr/w_data while capturing r_data. It returns one tagged response per accepted request. Data requests take priority, with a starvation guard that protects fetch.

Parameters:
MEM_BASE, 32'h0000_0000, lowest legal byte address
MEM_SIZE, 32'h0001_0000, legal range in bytes; legal when MEM_BASE <= addr < MEM_BASE+MEM_SIZE
STARVE_LIMIT, 4, consecutive cycles fetch may lose arbitration before it is forced through

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
if_req_valid  in  1  fetch request present
if_req_ready  out  1  fetch request accepted this cycle when both valid and ready are high
if_addr  in  32  fetch byte address
if_flush  in  1  discard any outstanding fetch response (redirect)
if_resp_valid  out  1  one-cycle fetch response pulse
if_resp_data  out  32  fetched instruction word
if_resp_err  out  1  fetch was misaligned or out of range
d_req_valid  in  1  data request present
d_req_ready  out  1  data request accepted
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data byte address
d_wdata  in  32  store data
d_resp_valid  out  1  one-cycle data response pulse
d_resp_rdata  out  32  load data; 0 for stores
d_resp_err  out  1  misaligned or out of range
mem_write_enabled  out  1  to SimulatedMemory write_enabled
mem_addr  out  32  to SimulatedMemory addr
mem_w_data  out  32  to SimulatedMemory w_data
mem_r_data  in  32  from SimulatedMemory r_data; combinational in mem_addr
busy  out  1  state != IDLE

Behaviour:
- rst low, asynchronous and active-low:
  - state = IDLE.
  - All outputs go to 0 immediately, including mem_write_enabled. Any in-flight store is aborted.
  - starve_cnt = 0.
  - Responses that were pending are lost.
- States are IDLE and ISSUE.
- IDLE:
  - if_req_ready and d_req_ready are high only when that port wins arbitration. At most one is high per cycle.
- Arbitration in IDLE:
  - Only one port valid: that port wins.
  - Both ports valid: data wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on each cycle where if_req_valid is high and fetch is not granted.
  - Clears on a fetch grant or when if_req_valid is low.
- Accept at edge E0 goes to ISSUE. The request is registered: port id, we, addr, wdata, err.
  - err = (addr[1:0] != 0) or addr outside range.
- ISSUE (exactly one cycle):
  - mem_addr = registered address.
  - mem_w_data = registered wdata, or 0 for loads.
  - mem_write_enabled = we & ~err. It is never asserted for fetches or erroneous requests.
  - Both readys are low.
- Edge E1 captures mem_r_data (forced to 0 when err or store) into the response registers and returns to IDLE.
- Response: the matching *_resp_valid is high for exactly the one cycle after E1. Latency is 2 cycles from accept. Peak throughput is one request per 2 cycles. The other port's resp_valid stays 0.
- No response backpressure: consumers must take the pulse.
- mem_addr/mem_w_data hold their last value in IDLE; mem_write_enabled is 0 in IDLE.
- if_flush:
  - If high in the ISSUE cycle of a fetch, or in its response cycle, if_resp_valid is suppressed (0).
  - The memory read still occurs.
  - Flush has no effect on data responses or on arbitration.
- A new request may be accepted in the same cycle as the previous response (IDLE coincides with the response cycle).
- Address wrap: the range check uses 33-bit arithmetic, so MEM_BASE+MEM_SIZE overflowing past 2^32 does not wrap.

Decomposition:
- Shared package mem_pkg:
  - port id enum (PORT_IF, PORT_D)
  - state enum (IDLE, ISSUE)
  - WORD_W = 32
  - response struct {valid, data, err}
- Natural sub-module: mem_addr_check. It is combinational, produces the misaligned/out-of-range err, and is instanced once per port.

Test Plan:
- Fetch only:
  - Stimulus: mem[0x100]=0x2402_0005; if_addr=0x100 accepted cycle 1.
  - Response: mem_addr=0x100 in cycle 2, if_resp_valid with data 0x2402_0005 in cycle 3, err=0.
- Store then load:
  - Stimulus: d_we=1, d_addr=0x40, d_wdata=0xDEAD_BEEF, then load 0x40.
  - Response: mem_write_enabled high exactly one cycle; load returns 0xDEAD_BEEF; store response rdata=0.
- Contention:
  - Stimulus: both ports valid continuously with STARVE_LIMIT=4.
  - Response: data wins the first grants; fetch is granted once starve_cnt reaches 4; starve_cnt then clears.
- Errors:
  - Stimulus: d_addr=0x42 store; fetch at MEM_BASE+MEM_SIZE.
  - Response: both give err=1, rdata 0, and mem_write_enabled never asserts.
- Flush:
  - Stimulus: fetch accepted, if_flush high in its ISSUE cycle.
  - Response: no if_resp_valid; the next request is accepted normally.
- Reset mid-store:
  - Stimulus: rst low asynchronously during ISSUE of a store.
  - Response: mem_write_enabled drops before the next clk edge; all outputs 0; after release, busy=0 and the next request is accepted.
